smc_stream: RTL and testbench

- Sequential, parametrised successor to the combinational six-device MOSFET calculator.
- Accepts NUM_DEV device triples (W, V_GS, V_DS) serially over a valid/ready handshake.
- Computes drain current (ID) or transconductance (gm) per device and keeps the values in a running sorted buffer.
- Selects the largest or smallest SEL_K values, accumulates the /3-scaled (optionally weighted) total, and returns it on a valid/ready output port.

---
 rtl/smc_stream.sv | 186 ++++++++++++++++++
 tb/tb_smc_stream.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/smc_stream.sv
// Streaming MOSFET calculator: sorts per-device ID/gm, sums scaled top/bottom SEL_K.
// Define SMC_SAT_CNT_EN to add the out_sat_cnt saturation-device counter.
module smc_stream #(
  parameter int NUM_DEV = 6,
  parameter int IN_W    = 3,
  parameter int SEL_K   = 3,
  parameter int OUT_W   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [IN_W-1:0]      W,
  input  logic [IN_W-1:0]      V_GS,
  input  logic [IN_W-1:0]      V_DS,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_n
`ifdef SMC_SAT_CNT_EN
  ,
  output logic [$clog2(NUM_DEV+1)-1:0] out_sat_cnt
`endif
);

  localparam int VAL_W = 3 * IN_W;
  localparam int CW    = $clog2(NUM_DEV + 1);
  localparam int KW    = $clog2(SEL_K + 1);
  localparam int IW    = $clog2(NUM_DEV);
  localparam int XW    = VAL_W + OUT_W + KW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_ACCUM,
    S_OUT
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_n;
  logic [1:0]         r_mode;
  logic [CW-1:0]      r_cnt;
  logic [KW-1:0]      r_k;
  logic [OUT_W-1:0]   r_acc;
  logic [VAL_W-1:0]   r_buf [NUM_DEV];
`ifdef SMC_SAT_CNT_EN
  logic [CW-1:0]      r_sat;
`endif

  logic [VAL_W-1:0]   w_w, w_vgs, w_vds, w_vt, w_val;
  logic               w_cut, w_sat, w_md;
  logic [CW-1:0]      w_n;
  logic               w_ge  [NUM_DEV];
  logic [VAL_W-1:0]   w_ins [NUM_DEV];
  logic [IW-1:0]      w_idx;
  logic [VAL_W-1:0]   w_div;
  logic [XW-1:0]      w_wt;
  logic [OUT_W-1:0]   w_term;
  logic [OUT_W-1:0]   w_acc_nx;
  logic               w_acc_in;

  assign w_acc_in = in_valid && r_in_ready;

  // Device model; the first beat uses the live mode, later beats the latched one
  always_comb begin
    w_w   = VAL_W'(W);
    w_vgs = VAL_W'(V_GS);
    w_vds = VAL_W'(V_DS);
    w_vt  = w_vgs - VAL_W'(1);
    w_cut = (V_GS <= IN_W'(1));
    w_sat = !w_cut && (w_vt <= w_vds);
    w_md  = (r_state == S_IDLE) ? mode[0] : r_mode[0];
    w_val = '0;
    if (w_cut)
      w_val = '0;
    else if (w_sat)
      w_val = w_md ? w_w * w_vt * w_vt
                   : (w_w * w_vt) << 1;
    else
      w_val = w_md ? w_w * w_vds * ((w_vt << 1) - w_vds)
                   : (w_w * w_vds) << 1;
  end

  // Insertion into descending buffer; equal entries keep precedence
  always_comb begin
    w_n = (r_state == S_IDLE) ? '0 : r_cnt;
    for (int i = 0; i < NUM_DEV; i++)
      w_ge[i] = (CW'(i) < w_n) && (r_buf[i] >= w_val);
    w_ins[0] = w_ge[0] ? r_buf[0] : w_val;
    for (int i = 1; i < NUM_DEV; i++)
      w_ins[i] = w_ge[i]   ? r_buf[i] :
                 w_ge[i-1] ? w_val    : r_buf[i-1];
  end

  always_comb begin
    w_idx    = r_mode[1] ? IW'(r_k)
                         : IW'(NUM_DEV - SEL_K) + IW'(r_k);
    w_div    = r_buf[w_idx] / VAL_W'(3);
    w_wt     = r_mode[0] ? XW'(r_k) + XW'(3) : XW'(1);
    w_term   = OUT_W'(XW'(w_div) * w_wt);
    w_acc_nx = r_acc + w_term;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_n     <= '0;
      r_mode      <= '0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      for (int i = 0; i < NUM_DEV; i++)
        r_buf[i] <= '0;
`ifdef SMC_SAT_CNT_EN
      r_sat       <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_acc_in) begin
            r_mode <= mode;
            r_buf  <= w_ins;
            r_cnt  <= CW'(1);
            r_acc  <= '0;
            r_k    <= '0;
`ifdef SMC_SAT_CNT_EN
            r_sat  <= CW'(w_sat);
`endif
            if (NUM_DEV == 1) begin
              r_state    <= S_ACCUM;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (w_acc_in) begin
            r_buf <= w_ins;
            r_cnt <= r_cnt + CW'(1);
`ifdef SMC_SAT_CNT_EN
            r_sat <= r_sat + CW'(w_sat);
`endif
            if (r_cnt == CW'(NUM_DEV - 1)) begin
              r_state    <= S_ACCUM;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_ACCUM: begin
          r_acc <= w_acc_nx;
          r_k   <= r_k + KW'(1);
          if (r_k == KW'(SEL_K - 1)) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
            r_out_n     <= w_acc_nx;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_cnt       <= '0;
            for (int i = 0; i < NUM_DEV; i++)
              r_buf[i] <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_n     = r_out_n;
`ifdef SMC_SAT_CNT_EN
  assign out_sat_cnt = r_sat;
`endif

endmodule

// File: tb/tb_smc_stream.sv
// Directed bench for smc_stream: frame results, latency, handshake, reset abort.
module tb_smc_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic [2:0] W, V_GS, V_DS;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_n;
`ifdef SMC_SAT_CNT_EN
  logic [2:0] out_sat_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int hs     = 0;

  smc_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .W         (W),
    .V_GS      (V_GS),
    .V_DS      (V_DS),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n     (out_n)
`ifdef SMC_SAT_CNT_EN
    ,
    .out_sat_cnt (out_sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && out_valid && out_ready) hs++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [1:0] m,
                           input logic [2:0] w,
                           input logic [2:0] g,
                           input logic [2:0] d);
    int n;
    mode     = m;
    W        = w;
    V_GS     = g;
    V_DS     = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(n < 100), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // kind: 0 sat 7/7/7, 1 gm W=i+1 Vgs=2 Vds=3, 2 triode W=i+1 Vgs=5 Vds=2, 3 cutoff
  task automatic frame(input logic [1:0] m0,
                       input logic [1:0] m1,
                       input int kind,
                       input int gap);
    logic [2:0] w, g, d;
    for (int i = 0; i < 6; i++) begin
      w = 3'(i + 1);
      g = 3'd0;
      d = 3'(i);
      case (kind)
        0: begin w = 3'd7; g = 3'd7; d = 3'd7; end
        1: begin g = 3'd2; d = 3'd3; end
        2: begin g = 3'd5; d = 3'd2; end
        default: ;
      endcase
      send_beat((i == 0) ? m0 : (m1 ^ 2'(i & 1)), w, g, d);
      if (gap != 0 && i < 5)
        repeat ((i % 3) + 1) @(negedge clk);
    end
  endtask

  task automatic get_result(input string tag,
                            input int exp,
                            input int exp_sat,
                            input int hold);
    int n;
    logic [9:0] held;
    n = 0;
    while (!out_valid && n < 50) begin
      check({tag, "_in_ready_accum"}, 32'(in_ready), 0);
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 3);
    check({tag, "_out_n"}, 32'(out_n), exp);
`ifdef SMC_SAT_CNT_EN
    check({tag, "_sat_cnt"}, 32'(out_sat_cnt), exp_sat);
`else
    if (exp_sat < 0) $display("unused sat %0d", exp_sat);
`endif
    held = out_n;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 1);
      check({tag, "_hold_out_n"}, 32'(out_n), 32'(held));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 1);
  endtask

  initial begin
    int hs0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 2'b00;
    W         = '0;
    V_GS      = '0;
    V_DS      = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_n", 32'(out_n), 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_rise", 32'(in_ready), 1);

    frame(2'b11, 2'b11, 0, 0);
    get_result("sat_id_large", 1008, 6, 0);
    frame(2'b00, 2'b00, 1, 0);
    get_result("sat_gm_small", 3, 6, 0);
    frame(2'b10, 2'b10, 1, 0);
    get_result("sat_gm_large", 9, 6, 0);
    frame(2'b01, 2'b01, 2, 0);
    get_result("tri_id_small", 88, 0, 0);
    frame(2'b11, 2'b11, 2, 0);
    get_result("tri_id_large", 232, 0, 0);
    frame(2'b11, 2'b00, 3, 0);
    get_result("cutoff", 0, 0, 0);
    frame(2'b11, 2'b11, 2, 1);
    get_result("gaps_hold", 232, 0, 5);

    send_beat(2'b11, 3'd7, 3'd7, 3'd7);
    send_beat(2'b11, 3'd7, 3'd7, 3'd7);
    send_beat(2'b11, 3'd7, 3'd7, 3'd7);
    hs0 = hs;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_n", 32'(out_n), 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_rise", 32'(in_ready), 1);
    frame(2'b01, 2'b11, 2, 0);
    get_result("after_rst_latch", 88, 0, 0);
    check("after_rst_one_out", hs - hs0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
